// File: rtl/gmii_tx_framer.sv
`timescale 1ns/1ps
// gmii_tx_framer
// Ethernet transmit framer for the GMII side of the RGMII PHY block. Takes a
// byte stream over valid/ready and emits preamble, SFD, payload, zero pad,
// optional FCS and inter-frame gap. Byte mode (1G) uses one clock per byte.
// Nibble mode (10/100) uses two clocks per byte, low nibble first, and
// mirrors the nibble onto gmii_txd[7:4].
//
// Build option: define GMII_TX_FCS_EN to generate and append the CRC-32 FCS.
// When it is undefined, upstream supplies the FCS inside the payload. In that
// build s_tuser raises gmii_tx_er on the slot of the final payload byte.
//
// Ports
//   gmii_tx_clk      transmit clock (125 / 25 / 2.5 MHz)
//   gmii_tx_reset_n  asynchronous active-low reset
//   speed_10_100     1 = nibble mode, 0 = byte mode, latched at frame start
//   s_tdata/s_tvalid/s_tlast/s_tuser/s_tready  payload stream
//   gmii_txd/gmii_tx_en/gmii_tx_er             GMII transmit outputs
//   tx_busy          frame start through end of IFG
//   frame_done       pulse on the last IFG clock
//   underrun         pulse when the stream starves mid-frame
module gmii_tx_framer #(
  parameter int IFG_BYTES   = 12,
  parameter int MIN_PAYLOAD = 60
) (
  input  logic       gmii_tx_clk,
  input  logic       gmii_tx_reset_n,
  input  logic       speed_10_100,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  input  logic       s_tuser,
  output logic       s_tready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       tx_busy,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [3:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    PAD,
`ifdef GMII_TX_FCS_EN
    FCS,
`endif
    ERR,
    DROP,
    IFG
  } state_t;

  // State that follows the last payload/pad byte.
`ifdef GMII_TX_FCS_EN
  localparam state_t TAIL_ST = FCS;
`else
  localparam state_t TAIL_ST = IFG;
`endif

  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
  localparam logic [15:0] MIN_CNT  = 16'(MIN_PAYLOAD);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef GMII_TX_FCS_EN
  // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte per call.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int b = 0; b < 8; b++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction
`endif

  state_t      state_q, state_n;
  logic        phase_q, phase_n;
  logic        nib_q, nib_n;
  logic [7:0]  slot_cnt_q, slot_cnt_n;
  logic [15:0] byte_cnt_q, byte_cnt_n;
  logic [7:0]  cur_byte_q, cur_byte_n;
  logic        cur_last_q, cur_last_n;
  logic        user_q, user_n;
  logic        starve;
  logic        slot_end;
`ifdef GMII_TX_FCS_EN
  logic [31:0] crc_q, crc_n;
`endif

  // Next-value outputs; every port is a flop loaded from these.
  logic [7:0] txb;
  logic [3:0] nib_v;
  logic       slot_end_n;
  logic [7:0] txd_n;
  logic       en_n, er_n, rdy_n, busy_n, done_n;

  assign slot_end = !nib_q || phase_q;

  always_comb begin
    state_n    = state_q;
    phase_n    = 1'b0;
    nib_n      = nib_q;
    slot_cnt_n = slot_cnt_q;
    byte_cnt_n = byte_cnt_q;
    cur_byte_n = cur_byte_q;
    cur_last_n = cur_last_q;
    user_n     = user_q;
    starve     = 1'b0;
`ifdef GMII_TX_FCS_EN
    crc_n      = crc_q;
`endif

    // Slots are two clocks in nibble mode; DROP is not slot-based.
    if (state_q != IDLE && state_q != DROP) phase_n = nib_q & ~phase_q;

    case (state_q)
      IDLE: begin
        if (s_tvalid) begin
          state_n    = PRE;
          nib_n      = speed_10_100;
          phase_n    = 1'b0;
          slot_cnt_n = 8'd0;
          byte_cnt_n = 16'd0;
          cur_last_n = 1'b0;
          user_n     = 1'b0;
`ifdef GMII_TX_FCS_EN
          crc_n      = 32'hFFFFFFFF;
`endif
        end
      end
      PRE: begin
        if (slot_end) begin
          if (slot_cnt_q == 8'd6) begin
            state_n    = SFD;
            slot_cnt_n = 8'd0;
          end else begin
            slot_cnt_n = slot_cnt_q + 8'd1;
          end
        end
      end
      SFD, DATA: begin
        if (slot_end) begin
          if (state_q == DATA && cur_last_q) begin
            // Last payload byte has just been driven.
            state_n    = (byte_cnt_q < MIN_CNT) ? PAD : TAIL_ST;
            slot_cnt_n = 8'd0;
          end else if (s_tvalid) begin
            // Accept clock: capture the byte for the next slot.
            state_n    = DATA;
            cur_byte_n = s_tdata;
            cur_last_n = s_tlast;
            user_n     = s_tlast & s_tuser;
            byte_cnt_n = sat_inc(byte_cnt_q);
`ifdef GMII_TX_FCS_EN
            crc_n      = crc_byte(crc_q, s_tdata);
`endif
          end else begin
            state_n = ERR;
            starve  = 1'b1;
          end
        end
      end
      PAD: begin
        if (slot_end) begin
          byte_cnt_n = sat_inc(byte_cnt_q);
`ifdef GMII_TX_FCS_EN
          crc_n      = crc_byte(crc_q, 8'h00);
`endif
          if (sat_inc(byte_cnt_q) >= MIN_CNT) begin
            state_n    = TAIL_ST;
            slot_cnt_n = 8'd0;
          end
        end
      end
`ifdef GMII_TX_FCS_EN
      FCS: begin
        if (slot_end) begin
          if (slot_cnt_q == 8'd3) begin
            state_n    = IFG;
            slot_cnt_n = 8'd0;
          end else begin
            slot_cnt_n = slot_cnt_q + 8'd1;
          end
        end
      end
`endif
      ERR: begin
        if (slot_end) state_n = DROP;
      end
      DROP: begin
        if (s_tvalid && s_tready && s_tlast) begin
          state_n    = IFG;
          slot_cnt_n = 8'd0;
        end
      end
      IFG: begin
        if (slot_end) begin
          if (slot_cnt_q == IFG_LAST) begin
            // A queued frame starts straight after the gap, so the wire sees
            // exactly IFG_BYTES idle slots between back-to-back frames.
            if (s_tvalid) begin
              state_n    = PRE;
              nib_n      = speed_10_100;
              phase_n    = 1'b0;
              slot_cnt_n = 8'd0;
              byte_cnt_n = 16'd0;
              cur_last_n = 1'b0;
              user_n     = 1'b0;
`ifdef GMII_TX_FCS_EN
              crc_n      = 32'hFFFFFFFF;
`endif
            end else begin
              state_n = IDLE;
            end
          end else begin
            slot_cnt_n = slot_cnt_q + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    txb   = 8'h00;
    en_n  = 1'b0;
    er_n  = 1'b0;
    nib_v = 4'h0;
`ifdef GMII_TX_FCS_EN
    case (state_n)
      FCS: begin
        en_n = 1'b1;
        er_n = user_n;
        case (slot_cnt_n[1:0])
          2'd0:    txb = ~crc_n[7:0];
          2'd1:    txb = ~crc_n[15:8];
          2'd2:    txb = ~crc_n[23:16];
          default: txb = ~crc_n[31:24];
        endcase
      end
      default: ;
    endcase
`endif
    case (state_n)
      PRE:  begin en_n = 1'b1; txb = 8'h55; end
      SFD:  begin en_n = 1'b1; txb = 8'hD5; end
      DATA: begin
        en_n = 1'b1;
        txb  = cur_byte_n;
`ifndef GMII_TX_FCS_EN
        er_n = user_n & cur_last_n;
`endif
      end
      PAD:  en_n = 1'b1;
      ERR:  begin en_n = 1'b1; er_n = 1'b1; end
      default: ;
    endcase
    slot_end_n = !nib_n || phase_n;
    nib_v      = phase_n ? txb[7:4] : txb[3:0];
    txd_n      = nib_n ? {nib_v, nib_v} : txb;
    rdy_n      = (state_n == DROP) ||
                 (slot_end_n && (state_n == SFD || (state_n == DATA && !cur_last_n)));
    busy_n     = (state_n != IDLE);
    done_n     = (state_n == IFG) && slot_end_n && (slot_cnt_n == IFG_LAST);
  end

  // Control and output registers
  always_ff @(posedge gmii_tx_clk or negedge gmii_tx_reset_n) begin
    if (!gmii_tx_reset_n) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      nib_q      <= 1'b0;
      slot_cnt_q <= 8'd0;
      byte_cnt_q <= 16'd0;
      cur_last_q <= 1'b0;
      user_q     <= 1'b0;
      s_tready   <= 1'b0;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_n;
      phase_q    <= phase_n;
      nib_q      <= nib_n;
      slot_cnt_q <= slot_cnt_n;
      byte_cnt_q <= byte_cnt_n;
      cur_last_q <= cur_last_n;
      user_q     <= user_n;
      s_tready   <= rdy_n;
      gmii_txd   <= txd_n;
      gmii_tx_en <= en_n;
      gmii_tx_er <= er_n;
      tx_busy    <= busy_n;
      frame_done <= done_n;
      underrun   <= starve;
    end
  end

  // Datapath registers
  always_ff @(posedge gmii_tx_clk) begin
    cur_byte_q <= cur_byte_n;
`ifdef GMII_TX_FCS_EN
    crc_q      <= crc_n;
`endif
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
`timescale 1ns/1ps
// Directed bench for gmii_tx_framer: byte/nibble frames, padding, underrun,
// back-to-back frames and asynchronous reset in mid-frame.
module tb_gmii_tx_framer;
  localparam int MINP = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       speed = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic       tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic       s_tready;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en, gmii_tx_er, tx_busy, frame_done, underrun;

  gmii_tx_framer #(.IFG_BYTES(12), .MIN_PAYLOAD(MINP)) dut (
    .gmii_tx_clk(clk), .gmii_tx_reset_n(rst_n), .speed_10_100(speed),
    .s_tdata(tdata), .s_tvalid(tvalid), .s_tlast(tlast), .s_tuser(tuser),
    .s_tready(s_tready), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en),
    .gmii_tx_er(gmii_tx_er), .tx_busy(tx_busy), .frame_done(frame_done),
    .underrun(underrun));

  always #4 clk = ~clk;

  int passed = 0, total = 0;
  byte unsigned pl[$];
  byte unsigned exp_q[$];
  bit   user_flag = 1'b0;

  // Wire monitor, sampled on the falling edge.
  byte unsigned cap[$];
  int en_cnt = 0, er_cnt = 0, done_cnt = 0, und_cnt = 0, busy_cnt = 0;
  int rdy_cnt = 0, rdy_b2b = 0, low_run = 1000, last_gap = 0, last_done_gap = 0;
  logic prev_rdy = 1'b0;

  always @(negedge clk) begin
    if (gmii_tx_en) begin
      cap.push_back(gmii_txd);
      en_cnt <= en_cnt + 1;
      if (low_run > 0) last_gap <= low_run;
    end
    if (gmii_tx_en && gmii_tx_er) er_cnt <= er_cnt + 1;
    low_run <= gmii_tx_en ? 0 : low_run + 1;
    if (frame_done) begin
      done_cnt      <= done_cnt + 1;
      last_done_gap <= gmii_tx_en ? 0 : low_run + 1;
    end
    if (underrun) und_cnt <= und_cnt + 1;
    if (tx_busy) busy_cnt <= busy_cnt + 1;
    if (s_tready) rdy_cnt <= rdy_cnt + 1;
    if (s_tready && prev_rdy) rdy_b2b <= rdy_b2b + 1;
    prev_rdy <= s_tready;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic build_exp();
    byte unsigned body[$];
    logic [31:0] c;
    body = pl;
    while (body.size() < MINP) body.push_back(8'h00);
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (body[k]) exp_q.push_back(body[k]);
`ifdef GMII_TX_FCS_EN
    c = 32'hFFFFFFFF;
    foreach (body[k]) begin
      c = c ^ {24'd0, body[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[31:24]);
`endif
    c = 32'd0;
  endtask

  // Feeds pl; drop_at >= 0 withholds that byte for one accept clock.
  task automatic send_frame(input int drop_at);
    int  i = 0, guard = 0;
    bit  dropped = 1'b0;
    tvalid = 1'b1;
    tdata  = pl[0];
    tlast  = (pl.size() == 1);
    tuser  = user_flag && (pl.size() == 1);
    while (i < pl.size() && guard < 5000) begin
      if (i == drop_at && !dropped) tvalid = 1'b0;
      @(negedge clk);
      guard++;
      if (s_tready) begin
        @(posedge clk);
        #1;
        if (!tvalid) begin
          dropped = 1'b1;
          tvalid  = 1'b1;
        end else begin
          i++;
          if (i < pl.size()) begin
            tdata = pl[i];
            tlast = (i == pl.size() - 1);
            tuser = user_flag && (i == pl.size() - 1);
          end else begin
            tvalid = 1'b0;
            tlast  = 1'b0;
            tuser  = 1'b0;
          end
        end
      end
    end
    if (guard >= 5000) begin
      total++;
      $display("FAIL send_frame: handshake timeout after %0d of %0d bytes", i, pl.size());
    end
  endtask

  task automatic wait_done(input int target, output bit ok);
    int g = 0;
    while (done_cnt < target && g < 4000) begin
      @(negedge clk);
      g++;
    end
    ok = (done_cnt >= target);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({s_tready, gmii_txd, gmii_tx_en, gmii_tx_er, tx_busy, frame_done, underrun} !== 14'd0)
      $display("FAIL reset_hold: outputs %b required all zero",
               {s_tready, gmii_txd, gmii_tx_en, gmii_tx_er, tx_busy, frame_done, underrun});
    else passed++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if ({s_tready, gmii_txd, gmii_tx_en, gmii_tx_er, tx_busy, frame_done, underrun} !== 14'd0)
      $display("FAIL reset_idle: outputs %b required all zero",
               {s_tready, gmii_txd, gmii_tx_en, gmii_tx_er, tx_busy, frame_done, underrun});
    else passed++;
  endtask

  task automatic test_byte_frame();
    int base, e0, d0, b0, r0, got, first;
    bit ok;
    pl = {};
    for (int k = 0; k < 64; k++) pl.push_back(8'(k));
    exp_q = {};
    build_exp();
    base = cap.size(); e0 = en_cnt; d0 = done_cnt; b0 = busy_cnt; r0 = er_cnt;
    send_frame(-1);
    wait_done(d0 + 1, ok);
    total++;
    if (!ok) $display("FAIL byte64_done: frame_done count %0d required %0d", done_cnt - d0, 1);
    else passed++;
    total++;
`ifdef GMII_TX_FCS_EN
    if (en_cnt - e0 != 76) $display("FAIL byte64_en: tx_en clocks %0d required 76", en_cnt - e0);
`else
    if (en_cnt - e0 != 72) $display("FAIL byte64_en: tx_en clocks %0d required 72", en_cnt - e0);
`endif
    else passed++;
    got = cap.size() - base;
    first = -1;
    for (int k = 0; k < exp_q.size() && k < got; k++)
      if (first < 0 && cap[base + k] !== exp_q[k]) first = k;
    total++;
    if (got != exp_q.size() || first >= 0)
      $display("FAIL byte64_stream: %0d bytes first bad index %0d, required %0d bytes",
               got, first, exp_q.size());
    else passed++;
    total++;
    if (last_done_gap != 12) $display("FAIL byte64_ifg: frame_done on idle clock %0d required 12", last_done_gap);
    else passed++;
    total++;
`ifdef GMII_TX_FCS_EN
    if (busy_cnt - b0 != 88) $display("FAIL byte64_busy: busy clocks %0d required 88", busy_cnt - b0);
`else
    if (busy_cnt - b0 != 84) $display("FAIL byte64_busy: busy clocks %0d required 84", busy_cnt - b0);
`endif
    else passed++;
    total++;
    if (er_cnt - r0 != 0) $display("FAIL byte64_er: tx_er clocks %0d required 0", er_cnt - r0);
    else passed++;
  endtask

  task automatic test_pad();
    int base, e0, d0, r0, got, first;
    bit ok;
    pl = {};
    for (int k = 0; k < 10; k++) pl.push_back(8'(k + 1));
    exp_q = {};
    build_exp();
    user_flag = 1'b1;
    base = cap.size(); e0 = en_cnt; d0 = done_cnt; r0 = er_cnt;
    send_frame(-1);
    user_flag = 1'b0;
    wait_done(d0 + 1, ok);
    total++;
    if (!ok) $display("FAIL pad_done: frame_done count %0d required 1", done_cnt - d0);
    else passed++;
    total++;
`ifdef GMII_TX_FCS_EN
    if (en_cnt - e0 != 72) $display("FAIL pad_en: tx_en clocks %0d required 72", en_cnt - e0);
`else
    if (en_cnt - e0 != 68) $display("FAIL pad_en: tx_en clocks %0d required 68", en_cnt - e0);
`endif
    else passed++;
    got = cap.size() - base;
    first = -1;
    for (int k = 0; k < exp_q.size() && k < got; k++)
      if (first < 0 && cap[base + k] !== exp_q[k]) first = k;
    total++;
    if (got != exp_q.size() || first >= 0)
      $display("FAIL pad_stream: %0d bytes first bad index %0d, required %0d bytes",
               got, first, exp_q.size());
    else passed++;
    total++;
`ifdef GMII_TX_FCS_EN
    if (er_cnt - r0 != 4) $display("FAIL pad_tuser_er: tx_er clocks %0d required 4", er_cnt - r0);
`else
    if (er_cnt - r0 != 1) $display("FAIL pad_tuser_er: tx_er clocks %0d required 1", er_cnt - r0);
`endif
    else passed++;
  endtask

  task automatic test_nibble();
    int base, e0, d0, q0, b2, got, first, bad_pre, bad_mirror;
    bit ok;
    logic [7:0] v;
    pl = {8'hA3, 8'h5C};
    exp_q = {};
    build_exp();
    speed = 1'b1;
    base = cap.size(); e0 = en_cnt; d0 = done_cnt; q0 = rdy_cnt; b2 = rdy_b2b;
    send_frame(-1);
    wait_done(d0 + 1, ok);
    speed = 1'b0;
    total++;
    if (!ok) $display("FAIL nib_done: frame_done count %0d required 1", done_cnt - d0);
    else passed++;
    total++;
`ifdef GMII_TX_FCS_EN
    if (en_cnt - e0 != 144) $display("FAIL nib_en: tx_en clocks %0d required 144", en_cnt - e0);
`else
    if (en_cnt - e0 != 136) $display("FAIL nib_en: tx_en clocks %0d required 136", en_cnt - e0);
`endif
    else passed++;
    got = cap.size() - base;
    bad_pre = 0;
    for (int k = 0; k < 15 && k < got; k++) if (cap[base + k][3:0] !== 4'h5) bad_pre++;
    v = (got > 19) ? cap[base + 15] : 8'h00;
    total++;
    if (got < 20 || bad_pre != 0 || v[3:0] !== 4'hD)
      $display("FAIL nib_preamble: %0d non-5 nibbles, sfd nibble %h required 0 and d", bad_pre, v[3:0]);
    else passed++;
    total++;
    if (got < 20 || {cap[base + 16][3:0], cap[base + 17][3:0], cap[base + 18][3:0], cap[base + 19][3:0]} !== 16'h3AC5)
      $display("FAIL nib_payload: nibbles %h required 3ac5",
               (got < 20) ? 16'h0 : {cap[base + 16][3:0], cap[base + 17][3:0], cap[base + 18][3:0], cap[base + 19][3:0]});
    else passed++;
    first = -1;
    bad_mirror = 0;
    for (int k = 0; k < 2 * exp_q.size() && k < got; k++) begin
      v = exp_q[k / 2];
      if (first < 0 && cap[base + k][3:0] !== ((k % 2) ? v[7:4] : v[3:0])) first = k;
      if (cap[base + k][7:4] !== cap[base + k][3:0]) bad_mirror++;
    end
    total++;
    if (got != 2 * exp_q.size() || first >= 0)
      $display("FAIL nib_stream: %0d nibbles first bad index %0d, required %0d nibbles",
               got, first, 2 * exp_q.size());
    else passed++;
    total++;
    if (bad_mirror != 0) $display("FAIL nib_mirror: %0d clocks with txd[7:4] != txd[3:0], required 0", bad_mirror);
    else passed++;
    total++;
    if (rdy_cnt - q0 != 2 || rdy_b2b - b2 != 0)
      $display("FAIL nib_ready: %0d ready clocks %0d adjacent, required 2 and 0", rdy_cnt - q0, rdy_b2b - b2);
    else passed++;
  endtask

  task automatic test_underrun();
    int base, e0, d0, u0, r0, got, first;
    bit ok;
    pl = {};
    for (int k = 0; k < 30; k++) pl.push_back(8'(8'h40 + k));
    exp_q = {};
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int k = 0; k < 20; k++) exp_q.push_back(pl[k]);
    exp_q.push_back(8'h00);
    base = cap.size(); e0 = en_cnt; d0 = done_cnt; u0 = und_cnt; r0 = er_cnt;
    send_frame(20);
    wait_done(d0 + 1, ok);
    total++;
    if (!ok || done_cnt - d0 != 1) $display("FAIL und_done: frame_done count %0d required 1", done_cnt - d0);
    else passed++;
    total++;
    if (und_cnt - u0 != 1) $display("FAIL und_pulse: underrun clocks %0d required 1", und_cnt - u0);
    else passed++;
    total++;
    if (er_cnt - r0 != 1) $display("FAIL und_err_slot: tx_en&tx_er clocks %0d required 1", er_cnt - r0);
    else passed++;
    total++;
    if (en_cnt - e0 != 29) $display("FAIL und_en: tx_en clocks %0d required 29", en_cnt - e0);
    else passed++;
    got = cap.size() - base;
    first = -1;
    for (int k = 0; k < exp_q.size() && k < got; k++)
      if (first < 0 && cap[base + k] !== exp_q[k]) first = k;
    total++;
    if (got != exp_q.size() || first >= 0)
      $display("FAIL und_stream: %0d bytes first bad index %0d, required %0d bytes",
               got, first, exp_q.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    int base, e0, d0, got, first;
    bit ok;
    exp_q = {};
    pl = {};
    for (int k = 0; k < 60; k++) pl.push_back(8'(8'h80 + k));
    build_exp();
    base = cap.size(); e0 = en_cnt; d0 = done_cnt;
    send_frame(-1);
    pl = {};
    for (int k = 0; k < 60; k++) pl.push_back(8'(8'hF0 - k));
    build_exp();
    send_frame(-1);
    wait_done(d0 + 2, ok);
    total++;
    if (!ok || done_cnt - d0 != 2) $display("FAIL b2b_done: frame_done count %0d required 2", done_cnt - d0);
    else passed++;
    total++;
    if (last_gap != 12) $display("FAIL b2b_gap: idle clocks between frames %0d required 12", last_gap);
    else passed++;
    total++;
`ifdef GMII_TX_FCS_EN
    if (en_cnt - e0 != 144) $display("FAIL b2b_en: tx_en clocks %0d required 144", en_cnt - e0);
`else
    if (en_cnt - e0 != 136) $display("FAIL b2b_en: tx_en clocks %0d required 136", en_cnt - e0);
`endif
    else passed++;
    got = cap.size() - base;
    first = -1;
    for (int k = 0; k < exp_q.size() && k < got; k++)
      if (first < 0 && cap[base + k] !== exp_q[k]) first = k;
    total++;
    if (got != exp_q.size() || first >= 0)
      $display("FAIL b2b_stream: %0d bytes first bad index %0d, required %0d bytes",
               got, first, exp_q.size());
    else passed++;
  endtask

  task automatic test_reset_midframe();
    int base, e0, d0, g, got, first;
    bit ok;
    pl = {};
    for (int k = 0; k < 10; k++) pl.push_back(8'(8'hC0 + k));
    e0 = en_cnt;
    tvalid = 1'b1;
    tdata  = pl[0];
    g = 0;
    while (en_cnt - e0 < 3 && g < 100) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (gmii_tx_en !== 1'b1 || gmii_txd !== 8'h55)
      $display("FAIL rst_mid_pre: tx_en %b txd %h required 1 and 55", gmii_tx_en, gmii_txd);
    else passed++;
    #1;
    rst_n  = 1'b0;
    tvalid = 1'b0;
    #1;
    total++;
    if ({s_tready, gmii_txd, gmii_tx_en, gmii_tx_er, tx_busy, frame_done, underrun} !== 14'd0)
      $display("FAIL rst_mid_async: outputs %b required all zero",
               {s_tready, gmii_txd, gmii_tx_en, gmii_tx_er, tx_busy, frame_done, underrun});
    else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    exp_q = {};
    build_exp();
    base = cap.size(); e0 = en_cnt; d0 = done_cnt;
    send_frame(-1);
    wait_done(d0 + 1, ok);
    total++;
    if (!ok) $display("FAIL rst_mid_done: frame_done count %0d required 1", done_cnt - d0);
    else passed++;
    got = cap.size() - base;
    first = -1;
    for (int k = 0; k < exp_q.size() && k < got; k++)
      if (first < 0 && cap[base + k] !== exp_q[k]) first = k;
    total++;
    if (got != exp_q.size() || first >= 0)
      $display("FAIL rst_mid_stream: %0d bytes first bad index %0d, required %0d bytes",
               got, first, exp_q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_byte_frame();
    test_pad();
    test_nibble();
    test_underrun();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
